// File: rtl/ocp_mem_slave_bridge_if.sv
// ---------------------------------------------------------------------------
// ocp_mem_slave_bridge_if.sv
// OCP single-transaction bundle between an OCP master and a slave responder.
//   m_cmd[2:0]     master -> slave  command (000 IDLE, 001 WR, 010 RD)
//   m_addr         master -> slave  command address
//   m_data         master -> slave  write data
//   m_resp_accept  master -> slave  master takes the current response
//   s_cmd_accept   slave -> master  one-cycle pulse, command taken
//   s_resp[1:0]    slave -> master  response (00 NULL, 01 DVA, 11 ERR)
//   s_data         slave -> master  read data
// ---------------------------------------------------------------------------
interface ocp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [2:0]            m_cmd;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_resp_accept;
    logic                  s_cmd_accept;
    logic [1:0]            s_resp;
    logic [DATA_WIDTH-1:0] s_data;

    modport master (
        output m_cmd, m_addr, m_data, m_resp_accept,
        input  s_cmd_accept, s_resp, s_data
    );

    modport slave (
        input  m_cmd, m_addr, m_data, m_resp_accept,
        output s_cmd_accept, s_resp, s_data
    );
endinterface

// File: rtl/ocp_mem_slave_bridge.sv
// ---------------------------------------------------------------------------
// ocp_mem_slave_bridge.sv
// OCP slave-side responder. Takes one OCP read/write command at a time,
// performs it as a single access on a simple variable-latency memory port
// and returns DVA (with read data) or ERR on OCP. A per-access timeout turns
// a memory that never acknowledges into an ERR response.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   enable     clock enable; all registers hold while 0
//   s_ocp      OCP slave bundle (command in, accept/response/data out)
//   mem_req    access request, held until mem_ack
//   mem_we     1 = write, 0 = read
//   mem_addr   access address
//   mem_wdata  write data
//   mem_rdata  read data, valid in the mem_ack cycle
//   mem_ack    access complete, only looked at while mem_req=1
//   busy       1 whenever a transaction is in progress
// ---------------------------------------------------------------------------
module ocp_mem_slave_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    ocp_if.slave                  s_ocp,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RESP     = 2'd2
    } state_t;

    state_t                state_q,        state_d;
    logic                  s_cmd_accept_q, s_cmd_accept_d;
    logic [1:0]            s_resp_q,       s_resp_d;
    logic [DATA_WIDTH-1:0] s_data_q,       s_data_d;
    logic                  mem_req_q,      mem_req_d;
    logic                  mem_we_q,       mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,     mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,    mem_wdata_d;
    logic [CNT_W-1:0]      cnt_q,          cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            s_cmd_accept_q <= 1'b0;
            s_resp_q       <= RESP_NULL;
            s_data_q       <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cnt_q          <= '0;
        end else if (enable) begin
            state_q        <= state_d;
            s_cmd_accept_q <= s_cmd_accept_d;
            s_resp_q       <= s_resp_d;
            s_data_q       <= s_data_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        s_cmd_accept_d = 1'b0;          // accept is a single-cycle pulse
        s_resp_d       = s_resp_q;
        s_data_d       = s_data_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cnt_d          = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (s_ocp.m_cmd == CMD_WR || s_ocp.m_cmd == CMD_RD) begin
                    mem_addr_d     = s_ocp.m_addr;
                    mem_wdata_d    = s_ocp.m_data;
                    mem_we_d       = (s_ocp.m_cmd == CMD_WR);
                    mem_req_d      = 1'b1;
                    s_cmd_accept_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = ST_MEM_WAIT;
                end else if (s_ocp.m_cmd != CMD_IDLE) begin
                    // Unsupported command: accept it and answer ERR
                    // without touching memory.
                    s_cmd_accept_d = 1'b1;
                    s_resp_d       = RESP_ERR;
                    state_d        = ST_RESP;
                end
            end

            ST_MEM_WAIT: begin
                // Ack is checked before the timeout so a same-cycle ack wins.
                if (mem_ack && mem_req_q) begin
                    mem_req_d = 1'b0;
                    s_resp_d  = RESP_DVA;
                    if (!mem_we_q)
                        s_data_d = mem_rdata;
                    state_d   = ST_RESP;
                end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    s_resp_d  = RESP_ERR;
                    state_d   = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturate so a disabled timeout never wraps.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (s_ocp.m_resp_accept) begin
                    s_resp_d = RESP_NULL;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_ocp.s_cmd_accept = s_cmd_accept_q;
    assign s_ocp.s_resp       = s_resp_q;
    assign s_ocp.s_data       = s_data_q;
    assign mem_req            = mem_req_q;
    assign mem_we             = mem_we_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ocp_mem_slave_bridge.sv
// ---------------------------------------------------------------------------
// tb_ocp_mem_slave_bridge.sv
// Directed bench for ocp_mem_slave_bridge with TIMEOUT_CYCLES=4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_ocp_mem_slave_bridge;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    ocp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ocp_mem_slave_bridge #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .s_ocp    (bus),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset             = 1'b0;
        enable            = 1'b1;
        bus.m_cmd         = 3'b000;
        bus.m_addr        = '0;
        bus.m_data        = '0;
        bus.m_resp_accept = 1'b0;
        mem_rdata         = '0;
        mem_ack           = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_accept", bus.s_cmd_accept, 0);
        chk("rst_resp",   bus.s_resp, 0);
        chk("rst_sdata",  bus.s_data, 0);
        chk("rst_req",    mem_req, 0);
        chk("rst_we",     mem_we, 0);
        chk("rst_addr",   mem_addr, 0);
        chk("rst_wdata",  mem_wdata, 0);
        chk("rst_busy",   busy, 0);
        reset = 1'b1;
        tick();

        // Write, ack after 3 request cycles
        bus.m_cmd  = 3'b001;
        bus.m_addr = 5'h0A;
        bus.m_data = 32'hDEADBEEF;
        tick();
        chk("wr_accept", bus.s_cmd_accept, 1);
        chk("wr_req1",   mem_req, 1);
        chk("wr_we",     mem_we, 1);
        chk("wr_addr",   mem_addr, 5'h0A);
        chk("wr_wdata",  mem_wdata, 32'hDEADBEEF);
        chk("wr_busy",   busy, 1);
        bus.m_cmd = 3'b000;
        tick();
        chk("wr_accept_clr", bus.s_cmd_accept, 0);
        chk("wr_req2",   mem_req, 1);
        chk("wr_resp_wait", bus.s_resp, 0);
        tick();
        chk("wr_req3",   mem_req, 1);
        chk("wr_addr_hold", mem_addr, 5'h0A);
        mem_ack = 1'b1;
        tick();
        chk("wr_req_drop", mem_req, 0);
        chk("wr_resp_dva", bus.s_resp, 2'b01);
        chk("wr_sdata_keep", bus.s_data, 0);
        mem_ack = 1'b0;
        tick();
        chk("wr_resp_hold", bus.s_resp, 2'b01);
        bus.m_resp_accept = 1'b1;
        tick();
        chk("wr_resp_null", bus.s_resp, 0);
        chk("wr_busy_clr",  busy, 0);
        bus.m_resp_accept = 1'b0;

        // Read, zero-wait memory
        bus.m_cmd  = 3'b010;
        bus.m_addr = 5'h1F;
        bus.m_data = '0;
        mem_rdata  = 32'h12345678;
        mem_ack    = 1'b1;
        tick();
        chk("rd_accept", bus.s_cmd_accept, 1);
        chk("rd_req",    mem_req, 1);
        chk("rd_we",     mem_we, 0);
        chk("rd_addr",   mem_addr, 5'h1F);
        chk("rd_resp_pre", bus.s_resp, 0);
        bus.m_cmd = 3'b000;
        tick();
        chk("rd_resp_dva", bus.s_resp, 2'b01);
        chk("rd_sdata",    bus.s_data, 32'h12345678);
        chk("rd_req_drop", mem_req, 0);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        bus.m_resp_accept = 1'b1;
        tick();
        chk("rd_resp_null", bus.s_resp, 0);
        bus.m_resp_accept = 1'b0;

        // Timeout: request high for exactly 4 cycles
        bus.m_cmd  = 3'b010;
        bus.m_addr = 5'h03;
        tick();
        chk("to_req1", mem_req, 1);
        bus.m_cmd = 3'b000;
        tick();
        chk("to_req2", mem_req, 1);
        tick();
        chk("to_req3", mem_req, 1);
        tick();
        chk("to_req4", mem_req, 1);
        chk("to_resp_pre", bus.s_resp, 0);
        tick();
        chk("to_req_drop", mem_req, 0);
        chk("to_resp_err", bus.s_resp, 2'b11);
        chk("to_sdata_keep", bus.s_data, 32'h12345678);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        chk("to_late_ack_resp", bus.s_resp, 2'b11);
        chk("to_late_ack_data", bus.s_data, 32'h12345678);
        chk("to_late_ack_req",  mem_req, 0);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        bus.m_resp_accept = 1'b1;
        tick();
        chk("to_resp_null", bus.s_resp, 0);
        chk("to_busy_clr",  busy, 0);
        bus.m_resp_accept = 1'b0;

        // Unsupported command
        bus.m_cmd = 3'b011;
        tick();
        chk("un_accept", bus.s_cmd_accept, 1);
        chk("un_req",    mem_req, 0);
        chk("un_resp",   bus.s_resp, 2'b11);
        chk("un_busy",   busy, 1);
        bus.m_cmd = 3'b000;
        tick();
        chk("un_accept_clr", bus.s_cmd_accept, 0);
        chk("un_resp_hold",  bus.s_resp, 2'b11);
        chk("un_req_idle",   mem_req, 0);
        bus.m_resp_accept = 1'b1;
        tick();
        chk("un_resp_null", bus.s_resp, 0);
        bus.m_resp_accept = 1'b0;

        // Back-to-back: WR held through RESP
        bus.m_cmd  = 3'b001;
        bus.m_addr = 5'h05;
        bus.m_data = 32'h00001111;
        mem_ack    = 1'b1;
        tick();
        chk("bb_accept1", bus.s_cmd_accept, 1);
        tick();
        chk("bb_accept_clr", bus.s_cmd_accept, 0);
        chk("bb_resp_dva",   bus.s_resp, 2'b01);
        mem_ack = 1'b0;
        tick();
        chk("bb_no_accept_resp", bus.s_cmd_accept, 0);
        bus.m_resp_accept = 1'b1;
        tick();
        chk("bb_resp_null",    bus.s_resp, 0);
        chk("bb_no_accept_ret", bus.s_cmd_accept, 0);
        chk("bb_idle",         busy, 0);
        bus.m_resp_accept = 1'b0;
        tick();
        chk("bb_accept2", bus.s_cmd_accept, 1);
        chk("bb_req2",    mem_req, 1);
        chk("bb_addr2",   mem_addr, 5'h05);
        chk("bb_wdata2",  mem_wdata, 32'h00001111);
        bus.m_cmd = 3'b000;
        mem_ack   = 1'b1;
        tick();
        chk("bb_resp2", bus.s_resp, 2'b01);
        chk("bb_sdata_keep", bus.s_data, 32'h12345678);
        mem_ack = 1'b0;
        bus.m_resp_accept = 1'b1;
        tick();
        bus.m_resp_accept = 1'b0;

        // Freeze: enable=0 for 5 cycles in MEM_WAIT
        bus.m_cmd  = 3'b010;
        bus.m_addr = 5'h07;
        tick();
        chk("fz_req_start", mem_req, 1);
        bus.m_cmd = 3'b000;
        tick();
        chk("fz_req_c1", mem_req, 1);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ack   = (i == 1 || i == 2);
            mem_rdata = 32'hBAD0BAD0;
            tick();
            chk("fz_req_hold",  mem_req, 1);
            chk("fz_resp_hold", bus.s_resp, 0);
            chk("fz_addr_hold", mem_addr, 5'h07);
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        enable    = 1'b1;
        tick();
        chk("fz_req_c2", mem_req, 1);
        tick();
        chk("fz_req_c3", mem_req, 1);
        chk("fz_resp_c3", bus.s_resp, 0);
        tick();
        chk("fz_timeout_req",  mem_req, 0);
        chk("fz_timeout_resp", bus.s_resp, 2'b11);
        chk("fz_sdata_keep",   bus.s_data, 32'h12345678);
        bus.m_resp_accept = 1'b1;
        tick();
        bus.m_resp_accept = 1'b0;

        // Async reset mid-MEM_WAIT, then a normal read
        bus.m_cmd  = 3'b010;
        bus.m_addr = 5'h09;
        tick();
        chk("ar_req_pre", mem_req, 1);
        chk("ar_accept_pre", bus.s_cmd_accept, 1);
        bus.m_cmd = 3'b000;
        reset = 1'b0;
        #1;
        chk("ar_req",    mem_req, 0);
        chk("ar_accept", bus.s_cmd_accept, 0);
        chk("ar_resp",   bus.s_resp, 0);
        chk("ar_busy",   busy, 0);
        chk("ar_addr",   mem_addr, 0);
        chk("ar_sdata",  bus.s_data, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_idle_resp", bus.s_resp, 0);
        bus.m_cmd  = 3'b010;
        bus.m_addr = 5'h1F;
        mem_rdata  = 32'hCAFEF00D;
        mem_ack    = 1'b1;
        tick();
        chk("ar_rd_accept", bus.s_cmd_accept, 1);
        chk("ar_rd_addr",   mem_addr, 5'h1F);
        bus.m_cmd = 3'b000;
        tick();
        chk("ar_rd_resp",  bus.s_resp, 2'b01);
        chk("ar_rd_sdata", bus.s_data, 32'hCAFEF00D);
        mem_ack = 1'b0;
        bus.m_resp_accept = 1'b1;
        tick();
        chk("ar_rd_null", bus.s_resp, 0);
        chk("ar_rd_busy", busy, 0);
        bus.m_resp_accept = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
